// File: rtl/sched_sequencer.sv
// Programmable schedule sequencer: steps a loaded control-word table, one word per cycle.
// Optional repeated passes are enabled by defining SCHED_REPEAT_EN (adds the repeat_n port).
module sched_sequencer #(
    parameter  int unsigned NUM_STEPS = 16,
    parameter  int unsigned SEL_W     = 4,
    parameter  int unsigned NUM_REGS  = 16,
    localparam int unsigned CW_W      = 6*SEL_W + 5 + NUM_REGS,
    localparam int unsigned AW        = $clog2(NUM_STEPS),
    localparam int unsigned LW        = $clog2(NUM_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [CW_W-1:0]     prog_data,
    input  logic                prog_len_we,
    input  logic [LW-1:0]       prog_len,
`ifdef SCHED_REPEAT_EN
    input  logic [7:0]          repeat_n,
`endif
    output logic                op_ready,
    output logic                busy,
    output logic                done_next,
    output logic [AW-1:0]       step_idx,
    output logic [SEL_W-1:0]    alu1_sel1,
    output logic [SEL_W-1:0]    alu1_sel2,
    output logic [SEL_W-1:0]    mul1_sel1,
    output logic [SEL_W-1:0]    mul1_sel2,
    output logic [SEL_W-1:0]    log1_sel1,
    output logic [SEL_W-1:0]    log1_sel2,
    output logic                alu1_op,
    output logic                mul1_op,
    output logic [1:0]          log1_op,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                result_en
);

    typedef struct packed {
        logic [SEL_W-1:0]    alu1_sel1;
        logic [SEL_W-1:0]    alu1_sel2;
        logic                alu1_op;
        logic [SEL_W-1:0]    mul1_sel1;
        logic [SEL_W-1:0]    mul1_sel2;
        logic                mul1_op;
        logic [SEL_W-1:0]    log1_sel1;
        logic [SEL_W-1:0]    log1_sel2;
        logic [1:0]          log1_op;
        logic [NUM_REGS-1:0] reg_en;
        logic                result_en;
    } cw_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   step, step_nx;
    logic [LW-1:0]   len;
    logic [LW-1:0]   len_sat;
    logic [LW-1:0]   len_eff;
    logic            last_step;
    logic [CW_W-1:0] tbl [NUM_STEPS];
    logic [CW_W-1:0] word;
    cw_t             cw;
    logic            prog_ok;
`ifdef SCHED_REPEAT_EN
    logic [7:0]      passes, pass_nx;
`endif

    // Writes only land while idle; a length write in the start cycle is seen by that run.
    assign prog_ok   = (state == IDLE);
    assign len_sat   = (prog_len > LW'(NUM_STEPS)) ? LW'(NUM_STEPS) : prog_len;
    assign len_eff   = (prog_ok && prog_len_we) ? len_sat : len;
    assign last_step = (LW'(step) == (len - LW'(1)));

    // State register plus step, length and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            len   <= '0;
`ifdef SCHED_REPEAT_EN
            passes <= '0;
`endif
        end else begin
            state <= state_nx;
            step  <= step_nx;
            if (prog_ok && prog_len_we) begin
                len <= len_sat;
            end
`ifdef SCHED_REPEAT_EN
            passes <= pass_nx;
`endif
        end
    end

    // Control-word table; out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                tbl[i] <= '0;
            end
        end else if (prog_ok && prog_we) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                if (prog_addr == AW'(i)) begin
                    tbl[i] <= prog_data;
                end
            end
        end
    end

    // Next-state and step sequencing.
    always_comb begin
        state_nx = state;
        step_nx  = step;
`ifdef SCHED_REPEAT_EN
        pass_nx  = passes;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    step_nx  = '0;
                    state_nx = (len_eff != '0) ? RUN : DONE;
`ifdef SCHED_REPEAT_EN
                    pass_nx  = repeat_n;
`endif
                end
            end
            RUN: begin
                if (!stall) begin
                    if (last_step) begin
                        step_nx = '0;
`ifdef SCHED_REPEAT_EN
                        if (passes != '0) begin
                            pass_nx = passes - 8'd1;
                        end else begin
                            state_nx = DONE;
                        end
`else
                        state_nx = DONE;
`endif
                    end else begin
                        step_nx = step + AW'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                step_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                step_nx  = '0;
            end
        endcase
    end

    assign op_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign done_next = (state == DONE);
    assign step_idx  = step;

    // Outputs decode the current word only in RUN; stall masks the write enables.
    assign word      = (state == RUN) ? tbl[step] : '0;
    assign cw        = cw_t'(word);
    assign alu1_sel1 = cw.alu1_sel1;
    assign alu1_sel2 = cw.alu1_sel2;
    assign alu1_op   = cw.alu1_op;
    assign mul1_sel1 = cw.mul1_sel1;
    assign mul1_sel2 = cw.mul1_sel2;
    assign mul1_op   = cw.mul1_op;
    assign log1_sel1 = cw.log1_sel1;
    assign log1_sel2 = cw.log1_sel2;
    assign log1_op   = cw.log1_op;
    assign reg_en    = stall ? '0 : cw.reg_en;
    assign result_en = stall ? 1'b0 : cw.result_en;

endmodule

// File: tb/tb_sched_sequencer.sv
// Bench for sched_sequencer: directed vector table plus randomized runs against a trace model.
module tb_sched_sequencer;

    localparam int NS  = 16;
    localparam int CWW = 45;

    logic            clk;
    logic            rst, start, stall, prog_we, prog_len_we;
    logic [3:0]      prog_addr;
    logic [CWW-1:0]  prog_data;
    logic [4:0]      prog_len;
    logic [7:0]      repeat_n;
    logic            op_ready, busy, done_next, alu1_op, mul1_op, result_en;
    logic [3:0]      step_idx, alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
    logic [1:0]      log1_op;
    logic [15:0]     reg_en;
    logic [CWW-1:0]  act_cw;

    int errors = 0;
    int checks = 0;

    sched_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len_we(prog_len_we), .prog_len(prog_len),
`ifdef SCHED_REPEAT_EN
        .repeat_n(repeat_n),
`endif
        .op_ready(op_ready), .busy(busy), .done_next(done_next), .step_idx(step_idx),
        .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2), .mul1_sel1(mul1_sel1),
        .mul1_sel2(mul1_sel2), .log1_sel1(log1_sel1), .log1_sel2(log1_sel2),
        .alu1_op(alu1_op), .mul1_op(mul1_op), .log1_op(log1_op),
        .reg_en(reg_en), .result_en(result_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_cw = {alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
                     log1_sel1, log1_sel2, log1_op, reg_en, result_en};

    typedef struct {
        bit             rst, start, stall, pwe;
        logic [3:0]     pa;
        logic [CWW-1:0] pd;
        bit             lwe;
        logic [4:0]     pl;
        bit             e_rdy, e_busy, e_done;
        logic [3:0]     e_step;
        logic [CWW-1:0] e_cw;
    } vec_t;

    vec_t           vq[$];
    logic [CWW-1:0] w[4];
    logic [CWW-1:0] mtbl[NS];
    int             mlen;
    int             seq[$];

    function automatic logic [CWW-1:0] mk(int a1, int a2, int aop, int m1, int m2, int mop,
                                          int l1, int l2, int lop, int re, int res);
        return {4'(a1), 4'(a2), 1'(aop), 4'(m1), 4'(m2), 1'(mop),
                4'(l1), 4'(l2), 2'(lop), 16'(re), 1'(res)};
    endfunction

    // Stall keeps selects/opcodes but clears reg_en and result_en (low 17 bits).
    function automatic logic [CWW-1:0] gate(logic [CWW-1:0] x);
        return {x[CWW-1:17], 17'b0};
    endfunction

    function automatic vec_t v(bit r, bit st, bit sl, bit pwe, int pa, logic [CWW-1:0] pd,
                               bit lwe, int pl, bit er, bit eb, bit ed, int es,
                               logic [CWW-1:0] ec);
        vec_t t;
        t.rst = r; t.start = st; t.stall = sl; t.pwe = pwe; t.pa = 4'(pa); t.pd = pd;
        t.lwe = lwe; t.pl = 5'(pl); t.e_rdy = er; t.e_busy = eb; t.e_done = ed;
        t.e_step = 4'(es); t.e_cw = ec;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_all(string tag, bit er, bit eb, bit ed, int es, logic [CWW-1:0] ec);
        chk({tag, " op_ready"}, 64'(op_ready), 64'(er));
        chk({tag, " busy"}, 64'(busy), 64'(eb));
        chk({tag, " done_next"}, 64'(done_next), 64'(ed));
        chk({tag, " step_idx"}, 64'(step_idx), 64'(es));
        chk({tag, " word"}, 64'(act_cw), 64'(ec));
    endtask

    task automatic noise();
        start       = 1'($urandom);
        stall       = 1'($urandom);
        prog_we     = 1'($urandom);
        prog_addr   = 4'($urandom);
        prog_data   = CWW'({$urandom, $urandom});
        prog_len_we = 1'($urandom);
        prog_len    = 5'($urandom);
        repeat_n    = 8'($urandom_range(0, 2));
    endtask

    // One idle cycle with random programming; the model commits what the DUT should.
    task automatic idle_cycle(input bit st);
        @(negedge clk);
        noise();
        rst = 1'b0;
        start = st;
        #1;
        chk_all("rnd idle", 1'b1, 1'b0, 1'b0, 0, '0);
        if (prog_we) mtbl[prog_addr] = prog_data;
        if (prog_len_we) mlen = (int'(prog_len) > NS) ? NS : int'(prog_len);
    endtask

    task automatic random_run();
        int passes;
        int cyc;
        logic [CWW-1:0] exp;
        repeat ($urandom_range(1, 4)) idle_cycle(1'b0);
        idle_cycle(1'b1);
        passes = 1;
`ifdef SCHED_REPEAT_EN
        passes = int'(repeat_n) + 1;
`endif
        seq.delete();
        for (int p = 0; p < passes; p++)
            for (int s = 0; s < mlen; s++) seq.push_back(s);
        cyc = 0;
        while (seq.size() > 0) begin
            @(negedge clk);
            noise();
            stall = ($urandom_range(0, 3) == 0);
            #1;
            exp = mtbl[seq[0]];
            if (stall) exp = gate(exp);
            chk_all("rnd run", 1'b0, 1'b1, 1'b0, seq[0], exp);
            if (!stall) void'(seq.pop_front());
            cyc++;
            if (cyc > 500) begin
                errors++;
                $display("FAIL rnd run: no completion after %0d cycles", cyc);
                break;
            end
        end
        @(negedge clk);
        noise();
        #1;
        chk_all("rnd done", 1'b0, 1'b0, 1'b1, 0, '0);
    endtask

    initial begin
        logic [CWW-1:0] ones;
        ones = '1;
        w[0] = mk(0, 1, 0, 4, 5, 1, 6, 7, 2, (1 << 2) | (1 << 9) | (1 << 12), 0);
        w[1] = mk(2, 3, 1, 8, 9, 0, 11, 12, 0, 'h0003, 0);
        w[2] = mk(15, 14, 0, 1, 2, 1, 3, 4, 3, 'h8000, 0);
        w[3] = mk(0, 0, 0, 0, 0, 0, 10, 13, 1, 1 << 14, 1);

        // Reset state, programming, plain 4-step run.
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,0,0,1,i,w[i],0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,1,4, 1,0,0,0,'0));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,i,w[i]));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        // Stall for 3 cycles at step 1.
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,0,w[0]));
        for (int i = 0; i < 3; i++) vq.push_back(v(0,0,1,0,0,'0,0,0, 0,1,0,1,gate(w[1])));
        for (int i = 1; i < 4; i++) vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,i,w[i]));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        // Programming and start during RUN/DONE are ignored.
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,1,0,1,0,ones,0,0, 0,1,0,0,w[0]));
        vq.push_back(v(0,0,0,0,0,'0,1,1, 0,1,0,1,w[1]));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 0,1,0,2,w[2]));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,3,w[3]));
        vq.push_back(v(0,1,0,1,1,ones,1,2, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,i,w[i]));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        // Zero length goes straight to DONE with nothing enabled.
        vq.push_back(v(0,0,0,0,0,'0,1,0, 1,0,0,0,'0));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,1,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        // Length 20 saturates to 16, written in the same cycle as start.
        vq.push_back(v(0,1,0,0,0,'0,1,20, 1,0,0,0,'0));
        for (int i = 0; i < NS; i++)
            vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,i,(i < 4) ? w[i] : '0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));
        // Reset at step 2: back to idle, no done pulse, length and table cleared.
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,0,w[0]));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,1,w[1]));
        vq.push_back(v(1,0,0,0,0,'0,0,0, 0,1,0,2,w[2]));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,1,1, 1,0,0,0,'0));
        vq.push_back(v(0,1,0,0,0,'0,0,0, 1,0,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,1,0,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 0,0,1,0,'0));
        vq.push_back(v(0,0,0,0,0,'0,0,0, 1,0,0,0,'0));

        rst = 1'b1; start = 1'b0; stall = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; prog_len_we = 1'b0; prog_len = '0; repeat_n = '0;
        repeat (2) @(negedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; start = vq[i].start; stall = vq[i].stall;
            prog_we = vq[i].pwe; prog_addr = vq[i].pa; prog_data = vq[i].pd;
            prog_len_we = vq[i].lwe; prog_len = vq[i].pl; repeat_n = '0;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_busy, vq[i].e_done,
                    int'(vq[i].e_step), vq[i].e_cw);
        end

        // Model matches the state left by the directed table: table cleared, len=1.
        for (int i = 0; i < NS; i++) mtbl[i] = '0;
        mlen = 1;
        repeat (40) random_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sched_sequencer.md
# sched_sequencer

Programmable schedule sequencer for the ALU/MUL/LOG datapath; replaces per-design fixed-schedule controllers. A control-word table loaded through a program port holds the schedule. On `start`, the block steps through the table one word per cycle, driving functional-unit operand selects, opcodes, register enables and `result_en`. It supports datapath stall and, optionally, repeated passes.

## Interface
- `NUM_STEPS`, 16: table depth, i.e. maximum schedule length; ≥2.
- `SEL_W`, 4: width of each operand-select field.
- `NUM_REGS`, 16: number of datapath register enables.
- `CW_W`, 6*SEL_W+5+NUM_REGS: control word width (derived; do not override).
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `stall` in 1: datapath not ready; freezes the current step.
- `prog_we` in 1: table write strobe.
- `prog_addr` in clog2(NUM_STEPS): table write address.
- `prog_data` in CW_W: control word to write.
- `prog_len_we` in 1: load the schedule length.
- `prog_len` in clog2(NUM_STEPS+1): schedule length, 0..NUM_STEPS.
- `repeat_n` in 8: extra passes. Present only with SCHED_REPEAT_EN.
- `op_ready` out 1: in IDLE; new start accepted.
- `busy` out 1: in RUN.
- `done_next` out 1: one-cycle completion pulse (DONE state).
- `step_idx` out clog2(NUM_STEPS): current step.
- `alu1_sel1`, `alu1_sel2`, `mul1_sel1`, `mul1_sel2`, `log1_sel1`, `log1_sel2` out SEL_W each: operand selects.
- `alu1_op`, `mul1_op` out 1 each; `log1_op` out 2: opcodes.
- `reg_en` out NUM_REGS: datapath register write enables.
- `result_en` out 1: capture the final result.

## Operation
- Control word layout, MSB→LSB: alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op, log1_sel1, log1_sel2, log1_op[1:0], reg_en[NUM_REGS-1:0], result_en.
- States are IDLE, RUN and DONE.
  - IDLE: `op_ready`=1.
    - `start`=1 with len>0 → RUN, step 0.
    - `start`=1 with len=0 → DONE.
  - RUN: the outputs decode `table[step_idx]`.
    - If `stall`=1: step holds; `reg_en` and `result_en` are forced to 0; selects and opcodes keep the word's values.
    - If `stall`=0 and step<len-1: step+1.
    - If `stall`=0 and step=len-1: → DONE (or wrap; see Configuration).
  - DONE: `done_next`=1 for exactly one cycle → IDLE.
- Outside RUN, all select, opcode and enable outputs are 0.
- `prog_we` and `prog_len_we` take effect only in IDLE; they are ignored in RUN and DONE.
- `prog_addr` ≥ NUM_STEPS: write is ignored.
- `prog_len` > NUM_STEPS: saturates to NUM_STEPS.
- A write and `start` in the same IDLE cycle: the write commits, and the run uses the new contents.
- `start` outside IDLE is ignored. There is no queueing.

## Timing
- Reset values: state IDLE, `op_ready`=1, every other output 0, len=0, every table word 0, pass counter 0.
- Reset mid-run returns to IDLE on the next edge. No `done_next` is produced.
- Start latency: `start` high at edge k puts step 0's word on the outputs during cycle k+1.
- Run length: a stall-free run of L steps occupies L cycles in RUN, then 1 cycle in DONE. `done_next` is high at cycle k+L+1. Each stalled cycle adds exactly 1 cycle.
- Table read is combinational from `step_idx`.
- All outputs decode from registered state. There is no input→output combinational path except `stall` gating `reg_en` and `result_en`.
- Earliest next start: `start` is accepted at the cycle after DONE, since IDLE has `op_ready`=1.

## Configuration
- `SCHED_REPEAT_EN` defined:
  - Adds the `repeat_n` input, latched at start.
  - At step=len-1 with `stall`=0 and passes remaining, the step wraps to 0 with no bubble and the remaining count decrements.
  - DONE is entered after `repeat_n`+1 passes.
  - `result_en` follows the table on every pass.
- `SCHED_REPEAT_EN` undefined: the port is absent, and the block always performs a single pass.

## Test plan
- Program the 4-step word set: step0 alu 0/1 op0 + mul 4/5 + log 6/7, reg_en bits 2, 9, 12; …; step3 log 10/13 op1, reg_en bit 14, result_en. Set len=4 and pulse start → words appear on cycles 1–4, `done_next` on cycle 5, `op_ready` on cycle 6.
- Same program with `stall` high on cycle 2 for 3 cycles → `step_idx` holds at 1, `reg_en`=0 during the stall, `done_next` on cycle 8.
- len=0 plus start → `done_next` the next cycle, with no enables asserted. Also write with prog_addr=NUM_STEPS → table unchanged.
- During RUN, assert prog_we to step 0 with 0x1FFF… and pulse start → ignored. The current run completes unchanged, and step 0 later reads the old word.
- Assert `rst` at step 2 → all outputs 0 and `op_ready`=1 next cycle, no `done_next`. len returns to 0.
- With SCHED_REPEAT_EN, len=3 and repeat_n=2 → steps 0,1,2,0,1,2,0,1,2 back-to-back, `result_en` 3 times, `done_next` at cycle 10.
